// File: rtl/io_display_port_pkg.sv
// io_display_port_pkg: shared widths and active-low gfedcba seven-segment glyphs
package io_display_port_pkg;
  localparam int DATA_W = 32;
  localparam int NIB_W = 4;
  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_C = 7'b010_0111;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
endpackage

// File: rtl/io_display_port_hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment glyph
module hex7seg
  import io_display_port_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg
);
  always_comb
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
endmodule

// File: rtl/io_display_port.sv
// io_display_port: debounced switch inputs, CPU output registers, per-channel hex digits
// Define IO_CHANGE_IRQ_EN to enable the sticky switch-change interrupt.
module io_display_port
  import io_display_port_pkg::*;
#(
  parameter int NUM_IN_CH  = 2,
  parameter int NUM_OUT_CH = 2,
  parameter int DEB_CYCLES = 4,
  parameter int SEL_W      = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NIB_W*NUM_IN_CH-1:0]           sw,
  input  logic                                 out_we,
  input  logic [SEL_W-1:0]                     out_sel,
  input  logic [DATA_W-1:0]                    out_wdata,
  output logic [DATA_W*NUM_IN_CH-1:0]          in_data,
  output logic [DATA_W*NUM_OUT_CH-1:0]         out_data,
  output logic [7*(NUM_IN_CH+NUM_OUT_CH)-1:0]  hex,
  output logic                                 irq,
  input  logic                                 irq_ack
);
  localparam int SW_W = NIB_W * NUM_IN_CH;
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic [SW_W-1:0] s1, s2, cand, stable;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] out_r [NUM_OUT_CH];
  logic accept;
  assign accept = (s2 == cand) && (cnt == CW'(DEB_CYCLES - 1));
  // cnt saturates once the candidate is accepted, so a steady input keeps accepting
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      stable <= '0;
      cnt <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt <= '0;
      end else if (accept) stable <= cand;
      else cnt <= cnt + CW'(1);
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int j = 0; j < NUM_OUT_CH; j++) out_r[j] <= '0;
    else for (int j = 0; j < NUM_OUT_CH; j++) if (out_we && out_sel == SEL_W'(j)) out_r[j] <= out_wdata;
`ifdef IO_CHANGE_IRQ_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) irq <= 1'b0;
    else irq <= (accept && cand != stable) || (irq && !irq_ack);
`else
  logic unused_ack;
  assign unused_ack = irq_ack;
  assign irq = 1'b0;
`endif
  for (genvar k = 0; k < NUM_IN_CH; k++) begin : g_in
    assign in_data[DATA_W*k +: DATA_W] = {{(DATA_W-NIB_W){1'b0}}, stable[NIB_W*k +: NIB_W]};
    hex7seg u_seg (.nib(stable[NIB_W*k +: NIB_W]), .seg(hex[7*k +: 7]));
  end
  for (genvar j = 0; j < NUM_OUT_CH; j++) begin : g_out
    assign out_data[DATA_W*j +: DATA_W] = out_r[j];
    hex7seg u_seg (.nib(out_r[j][NIB_W-1:0]), .seg(hex[7*(NUM_IN_CH+j) +: 7]));
  end
endmodule
